// File: rtl/bit_unpacker_pkg.sv
// Shared definitions for the compression datapath.
// Holds the default bit-unpacker geometry and the encoding of the cause
// behind a rejected read (the unpacker exposes only a 1-bit o_err pulse,
// the cause is kept internally for debug visibility).
package bit_unpacker_pkg;

    localparam int unsigned BU_WIDTH   = 256;  // bit-buffer capacity
    localparam int unsigned BU_I_WIDTH = 128;  // input word width
    localparam int unsigned BU_O_WIDTH = 64;   // maximum field width per read

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_UNDERFLOW   = 2'd1,  // fewer bits buffered than requested
        ERR_ILLEGAL_LEN = 2'd2   // requested length above O_WIDTH
    } err_cause_e;

endpackage

// File: rtl/bit_unpacker_shifter.sv
// barrel_shifter_l1: logarithmic left shifter with zero fill.
// Ports:
//   i_data  WIDTH   data to shift
//   i_amt   SH_BIT  shift amount; amounts >= WIDTH yield all zeros
//   o_data  WIDTH   i_data << i_amt
module barrel_shifter_l1 #(
    parameter int WIDTH  = 256,
    parameter int SH_BIT = 9
) (
    input  logic [WIDTH-1:0]  i_data,
    input  logic [SH_BIT-1:0] i_amt,
    output logic [WIDTH-1:0]  o_data
);

    logic [WIDTH-1:0] data;

    // One stage per amount bit; stage s shifts by 2**s when its bit is set.
    always_comb begin
        data = i_data;
        for (int s = 0; s < SH_BIT; s++) begin
            if (i_amt[s]) begin
                data = data << (32'd1 << s);
            end
        end
    end

    assign o_data = data;

endmodule

// File: rtl/bit_unpacker.sv
// bit_unpacker: turns a stream of packed I_WIDTH-bit words (oldest bit at the
// word MSB) into variable-length fields of 0..O_WIDTH bits.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               discard all buffered bits
//   i_valid, i_word       input word handshake (with o_ready)
//   o_ready               room for one more word (registered state only)
//   i_rd_en, i_rd_len     consume i_rd_len bits this cycle
//   o_field               next i_rd_len bits, right-justified, zero-extended
//   o_avail               a read of i_rd_len would be accepted
//   o_count               valid bits held in the buffer
//   o_err                 one-cycle pulse after a rejected read
module bit_unpacker
    import bit_unpacker_pkg::*;
#(
    parameter int WIDTH   = BU_WIDTH,
    parameter int I_WIDTH = BU_I_WIDTH,
    parameter int O_WIDTH = BU_O_WIDTH,
    parameter int LEN_BIT = $clog2(O_WIDTH + 1),
    parameter int CNT_BIT = $clog2(WIDTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [I_WIDTH-1:0] i_word,
    output logic               o_ready,
    input  logic               i_rd_en,
    input  logic [LEN_BIT-1:0] i_rd_len,
    output logic [O_WIDTH-1:0] o_field,
    output logic               o_avail,
    output logic [CNT_BIT-1:0] o_count,
    output logic               o_err
);

    localparam int SLACK = WIDTH - I_WIDTH;

    logic [WIDTH-1:0]   buf_q, buf_d;
    logic [CNT_BIT-1:0] count_q, count_d;
    err_cause_e         err_q, err_d;

    logic [CNT_BIT-1:0] rd_len_ext;
    logic [CNT_BIT-1:0] place_amt;
    logic [CNT_BIT-1:0] cons_amt;
    logic               rd_len_ok;
    logic               read_ok;
    logic               load_ok;
    logic [WIDTH-1:0]   word_ext;
    logic [WIDTH-1:0]   word_placed;
    logic [WIDTH-1:0]   merged;
    logic [WIDTH-1:0]   shifted;
    logic [O_WIDTH-1:0] field_top;
    logic [LEN_BIT:0]   field_sh;

    assign rd_len_ext = CNT_BIT'(i_rd_len);
    assign rd_len_ok  = (i_rd_len <= LEN_BIT'(O_WIDTH));
    assign o_avail    = rd_len_ok && (count_q >= rd_len_ext);
    assign o_ready    = (count_q <= CNT_BIT'(SLACK));
    assign read_ok    = i_rd_en && o_avail;
    assign load_ok    = i_valid && o_ready;
    assign o_count    = count_q;
    assign o_err      = (err_q != ERR_NONE);

    // A word is placed directly below the bits currently held, then the
    // merged buffer is shifted by the consumed length. Because consumed bits
    // are always taken from the top, this equals "read first, then load".
    assign place_amt = o_ready ? (CNT_BIT'(SLACK) - count_q) : '0;
    assign cons_amt  = read_ok ? rd_len_ext : '0;
    assign word_ext  = WIDTH'(i_word);
    assign merged    = buf_q | (load_ok ? word_placed : '0);

    barrel_shifter_l1 #(
        .WIDTH  (WIDTH),
        .SH_BIT (CNT_BIT)
    ) u_place (
        .i_data (word_ext),
        .i_amt  (place_amt),
        .o_data (word_placed)
    );

    barrel_shifter_l1 #(
        .WIDTH  (WIDTH),
        .SH_BIT (CNT_BIT)
    ) u_consume (
        .i_data (merged),
        .i_amt  (cons_amt),
        .o_data (shifted)
    );

    // Length 0 shifts by O_WIDTH and yields zero; illegal lengths wrap to a
    // large shift and also yield zero.
    assign field_top = buf_q[WIDTH-1 -: O_WIDTH];
    assign field_sh  = (LEN_BIT+1)'(O_WIDTH) - {1'b0, i_rd_len};
    assign o_field   = field_top >> field_sh;

    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        err_d   = ERR_NONE;
        if (i_flush) begin
            buf_d   = '0;
            count_d = '0;
        end else begin
            buf_d   = shifted;
            count_d = count_q - cons_amt + (load_ok ? CNT_BIT'(I_WIDTH) : '0);
            if (i_rd_en && !o_avail) begin
                err_d = rd_len_ok ? ERR_UNDERFLOW : ERR_ILLEGAL_LEN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_q   <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bit_unpacker.sv
module tb_bit_unpacker;

    logic         i_clk;
    logic         i_rst;
    logic         i_flush;
    logic         i_valid;
    logic [127:0] i_word;
    logic         o_ready;
    logic         i_rd_en;
    logic [6:0]   i_rd_len;
    logic [63:0]  o_field;
    logic         o_avail;
    logic [8:0]   o_count;
    logic         o_err;

    int checks = 0;
    int errors = 0;

    bit q[$];

    bit_unpacker dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .i_word   (i_word),
        .o_ready  (o_ready),
        .i_rd_en  (i_rd_en),
        .i_rd_len (i_rd_len),
        .o_field  (o_field),
        .o_avail  (o_avail),
        .o_count  (o_count),
        .o_err    (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_flush  = 1'b0;
        i_valid  = 1'b0;
        i_word   = '0;
        i_rd_en  = 1'b0;
        i_rd_len = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic load_word(input logic [127:0] w);
        i_valid = 1'b1;
        i_word  = w;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic read_len(input int len);
        i_rd_en  = 1'b1;
        i_rd_len = 7'(len);
        tick();
        i_rd_en  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (o_count !== 9'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", o_count);
        end
        checks++;
        if (o_ready !== 1'b1 || o_err !== 1'b0) begin
            errors++; $display("FAIL reset_ready_err: got ready=%b err=%b want 1,0", o_ready, o_err);
        end
        i_rd_len = 7'd0; #1;
        checks++;
        if (o_avail !== 1'b1 || o_field !== 64'd0) begin
            errors++; $display("FAIL reset_len0: got avail=%b field=%h want 1,0", o_avail, o_field);
        end
        i_rd_len = 7'd1; #1;
        checks++;
        if (o_avail !== 1'b0) begin
            errors++; $display("FAIL reset_len1_avail: got %b want 0", o_avail);
        end
        i_rd_len = 7'd0;
    endtask

    task automatic test_load_read();
        do_reset();
        load_word({4'hF, 124'd0});
        checks++;
        if (o_count !== 9'd128) begin
            errors++; $display("FAIL load_count: got %0d want 128", o_count);
        end
        i_rd_en = 1'b1; i_rd_len = 7'd4; #1;
        checks++;
        if (o_field !== 64'hF || o_avail !== 1'b1) begin
            errors++; $display("FAIL read4_field: got field=%h avail=%b want f,1", o_field, o_avail);
        end
        tick();
        i_rd_en = 1'b0;
        checks++;
        if (o_count !== 9'd124) begin
            errors++; $display("FAIL read4_count: got %0d want 124", o_count);
        end
    endtask

    task automatic test_same_cycle();
        // continues from count=124 with all-zero remaining bits
        i_rd_en = 1'b1; i_rd_len = 7'd60;
        i_valid = 1'b1; i_word = 128'h8123_4567_89AB_CDEF_0FED_CBA9_8765_4321;
        tick();
        idle_inputs();
        checks++;
        if (o_count !== 9'd192 || o_ready !== 1'b0) begin
            errors++; $display("FAIL same_cycle_count: got count=%0d ready=%b want 192,0", o_count, o_ready);
        end
        i_rd_len = 7'd64; #1;
        checks++;
        if (o_field !== 64'd0) begin
            errors++; $display("FAIL same_cycle_old_bits: got %h want 0", o_field);
        end
        read_len(64);
        i_rd_len = 7'd64; #1;
        checks++;
        if (o_field !== 64'h8123_4567_89AB_CDEF || o_count !== 9'd128) begin
            errors++; $display("FAIL same_cycle_new_word: got field=%h count=%0d want 8123456789abcdef,128", o_field, o_count);
        end
        read_len(64);
        i_rd_len = 7'd64; #1;
        checks++;
        if (o_field !== 64'h0FED_CBA9_8765_4321) begin
            errors++; $display("FAIL same_cycle_low_half: got %h want 0fedcba987654321", o_field);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_word(128'hA5A5);
        i_rd_en = 1'b1; i_rd_len = 7'd64;
        load_word(128'h5A5A);
        i_rd_en = 1'b0;
        read_len(62);
        checks++;
        if (o_count !== 9'd130) begin
            errors++; $display("FAIL bp_setup_count: got %0d want 130", o_count);
        end
        i_valid = 1'b1; i_word = {128{1'b1}}; #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_low: got %b want 0", o_ready);
        end
        tick();
        checks++;
        if (o_count !== 9'd130) begin
            errors++; $display("FAIL bp_not_taken: got %0d want 130", o_count);
        end
        i_rd_en = 1'b1; i_rd_len = 7'd2;
        tick();
        i_rd_en = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_count !== 9'd128) begin
            errors++; $display("FAIL bp_ready_back: got ready=%b count=%0d want 1,128", o_ready, o_count);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_error();
        do_reset();
        load_word(128'h1);
        read_len(64);
        read_len(54);
        i_rd_len = 7'd10; #1;
        checks++;
        if (o_count !== 9'd10 || o_avail !== 1'b1) begin
            errors++; $display("FAIL err_boundary: got count=%0d avail=%b want 10,1", o_count, o_avail);
        end
        i_rd_len = 7'd11; #1;
        checks++;
        if (o_avail !== 1'b0) begin
            errors++; $display("FAIL err_avail11: got %b want 0", o_avail);
        end
        read_len(11);
        checks++;
        if (o_err !== 1'b1 || o_count !== 9'd10) begin
            errors++; $display("FAIL err_underflow: got err=%b count=%0d want 1,10", o_err, o_count);
        end
        tick();
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got %b want 0", o_err);
        end
        read_len(65);
        checks++;
        if (o_err !== 1'b1 || o_count !== 9'd10) begin
            errors++; $display("FAIL err_len65: got err=%b count=%0d want 1,10", o_err, o_count);
        end
        tick();
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL err_len65_clear: got %b want 0", o_err);
        end
    endtask

    task automatic test_flush();
        do_reset();
        load_word({128{1'b1}});
        load_word({128{1'b1}});
        checks++;
        if (o_count !== 9'd256 || o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_setup: got count=%0d ready=%b want 256,0", o_count, o_ready);
        end
        i_flush = 1'b1; i_valid = 1'b1; i_word = {128{1'b1}};
        i_rd_en = 1'b1; i_rd_len = 7'd8;
        tick();
        idle_inputs();
        i_rd_len = 7'd64; #1;
        checks++;
        if (o_count !== 9'd0 || o_field !== 64'd0 || o_err !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got count=%0d field=%h err=%b want 0,0,0", o_count, o_field, o_err);
        end
        load_word(128'h1);
        read_len(64);
        i_rd_len = 7'd64; #1;
        checks++;
        if (o_field !== 64'h1) begin
            errors++; $display("FAIL flush_no_residue: got %h want 1", o_field);
        end
        i_rd_len = 7'd0;
    endtask

    task automatic test_random_stream();
        logic [63:0]  exp_field;
        logic [127:0] w;
        int           len;
        int           sz;
        bit           exp_avail;
        bit           exp_ready;
        bit           rd;
        bit           vld;
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            vld = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(0, 64);
            w   = {$urandom, $urandom, $urandom, $urandom};
            i_valid  = vld;
            i_word   = w;
            i_rd_en  = rd;
            i_rd_len = 7'(len);
            #1;
            sz        = q.size();
            exp_avail = (sz >= len);
            exp_ready = (sz <= 128);
            checks++;
            if (o_count !== 9'(sz) || o_ready !== exp_ready || o_avail !== exp_avail) begin
                errors++;
                $display("FAIL rand_state cyc %0d: got count=%0d ready=%b avail=%b want %0d,%b,%b",
                         cyc, o_count, o_ready, o_avail, sz, exp_ready, exp_avail);
            end
            if (exp_avail) begin
                exp_field = '0;
                for (int i = 0; i < len; i++) begin
                    exp_field = {exp_field[62:0], q[i]};
                end
                checks++;
                if (o_field !== exp_field) begin
                    errors++;
                    $display("FAIL rand_field cyc %0d len %0d: got %h want %h", cyc, len, o_field, exp_field);
                end
            end
            if (rd && exp_avail) begin
                for (int i = 0; i < len; i++) void'(q.pop_front());
            end
            if (vld && exp_ready) begin
                for (int i = 127; i >= 0; i--) q.push_back(w[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_read();
        test_same_cycle();
        test_backpressure();
        test_error();
        test_flush();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
